inst_fetch_queue: RTL and testbench

//   Decoupling queue between the dual-fetch ICache response (two 32-bit instructions per

---
 rtl/inst_fetch_queue_pkg.sv | 18 +
 rtl/inst_fetch_queue.sv | 179 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-path types for the instruction fetch queue and the decode stage.
package inst_fetch_queue_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t inst;
   } fetch_entry_t;

   localparam int unsigned FETCH_QUEUE_DEPTH  = 8;
   localparam int unsigned FETCH_MAX_INFLIGHT = 2;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-enqueue / dual-dequeue instruction queue between the ICache response and decode.
// Throttles ICache requests so every outstanding response has guaranteed space.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = FETCH_QUEUE_DEPTH,
   parameter int unsigned MAX_INFLIGHT = FETCH_MAX_INFLIGHT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_fire,
   output logic                       req_allow,
   input  logic                       resp_valid,
   input  logic [63:0]                resp_data,
   input  logic [31:0]                resp_pc,
   input  logic [1:0]                 resp_mask,
   input  logic                       flush,
   output logic [1:0]                 deq_valid,
   output logic [31:0]                deq_inst0,
   output logic [31:0]                deq_pc0,
   output logic [31:0]                deq_inst1,
   output logic [31:0]                deq_pc1,
   input  logic [1:0]                 deq_cnt,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned FW = CW + 1;
   localparam int unsigned IW = $clog2(MAX_INFLIGHT + 2) + 1;

   fetch_entry_t mem_q [DEPTH];

   logic [CW-1:0] head_q, head_d;
   logic [CW-1:0] tail_q, tail_d;
   logic [IW-1:0] inflight_q, inflight_d;
   logic [IW-1:0] drop_q, drop_d;

   logic [CW-1:0] occ;
   logic [CW-1:0] head_p1;
   logic [CW-1:0] tail_p1;
   logic [1:0]    avail;
   logic [1:0]    deq_n;
   logic [1:0]    enq_req;
   logic [1:0]    enq_n;
   logic          enq_ok;
   logic          resp_ret;
   logic [FW-1:0] free_enq;
   logic [31:0]   free_now;
   logic [31:0]   need;
   fetch_entry_t  wr_e0;
   fetch_entry_t  wr_e1;

   // ---------------------------------------------------------------------------------------
   // Occupancy and read side
   // ---------------------------------------------------------------------------------------
   always_comb begin
      occ     = tail_q - head_q;
      head_p1 = head_q + CW'(1);
      tail_p1 = tail_q + CW'(1);

      avail = 2'd0;
      if (!reset) begin
         if (occ > CW'(1)) begin
            avail = 2'd2;
         end else begin
            avail = {1'b0, occ[0]};
         end
      end

      unique case (avail)
         2'd2:    deq_valid = 2'b11;
         2'd1:    deq_valid = 2'b01;
         default: deq_valid = 2'b00;
      endcase

      // Over-consumption by decode is clamped to what is actually presented.
      deq_n = (deq_cnt > avail) ? avail : deq_cnt;

      count     = reset ? '0 : occ;
      deq_inst0 = mem_q[head_q[PW-1:0]].inst;
      deq_pc0   = mem_q[head_q[PW-1:0]].pc;
      deq_inst1 = mem_q[head_p1[PW-1:0]].inst;
      deq_pc1   = mem_q[head_p1[PW-1:0]].pc;
   end

   // ---------------------------------------------------------------------------------------
   // Write side
   // ---------------------------------------------------------------------------------------
   always_comb begin
      enq_req = popcount2(resp_mask);
      enq_ok  = resp_valid && (drop_q == '0) && !flush && !reset;

      // Slots vacated by this cycle's dequeue are safe to refill: reads are combinational.
      free_enq = FW'(DEPTH) - {1'b0, occ} + FW'(deq_n);

      enq_n = 2'd0;
      if (enq_ok) begin
         if (FW'(enq_req) > free_enq) begin
            enq_n = free_enq[1:0];
         end else begin
            enq_n = enq_req;
         end
      end

      wr_e0 = '{pc: resp_pc,          inst: resp_data[31:0]};
      wr_e1 = '{pc: resp_pc + 32'd4,  inst: resp_data[63:32]};
   end

   // Storage is intentionally not reset; validity comes only from the pointers.
   always_ff @(posedge clk) begin
      if (enq_n != 2'd0) begin
         mem_q[tail_q[PW-1:0]] <= wr_e0;
      end
      if (enq_n == 2'd2) begin
         mem_q[tail_p1[PW-1:0]] <= wr_e1;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Pointer, in-flight and drop bookkeeping
   // ---------------------------------------------------------------------------------------
   always_comb begin
      head_d     = head_q + CW'(deq_n);
      tail_d     = tail_q + CW'(enq_n);
      resp_ret   = resp_valid && (inflight_q != '0);
      inflight_d = inflight_q;
      drop_d     = drop_q;

      if (req_fire && !resp_ret) begin
         if (inflight_q != '1) begin
            inflight_d = inflight_q + IW'(1);
         end
      end else if (!req_fire && resp_ret) begin
         inflight_d = inflight_q - IW'(1);
      end

      if (flush) begin
         head_d = '0;
         tail_d = '0;
         drop_d = inflight_d;
      end else if (resp_valid && (drop_q != '0)) begin
         drop_d = drop_q - IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Request throttle: live requests each reserve two slots; dropped ones reserve none.
   // ---------------------------------------------------------------------------------------
   always_comb begin
      free_now  = DEPTH - 32'(occ);
      need      = (32'(inflight_q - drop_q) + 32'd1) << 1;
      req_allow = !flush && !reset && (32'(inflight_q) < MAX_INFLIGHT) && (free_now >= need);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_deq_cnt: assert (flush || (deq_cnt <= avail));
         a_resp_no_req: assert (!(resp_valid && (inflight_q == '0)));
         a_mask_legal: assert (!(resp_valid && (resp_mask == 2'b10)));
         a_no_overflow: assert (!(enq_ok && (FW'(enq_req) > free_enq)));
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with hand-computed expectations.
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned MAXI  = 2;

   logic                    clk;
   logic                    reset;
   logic                    req_fire;
   logic                    req_allow;
   logic                    resp_valid;
   logic [63:0]             resp_data;
   logic [31:0]             resp_pc;
   logic [1:0]              resp_mask;
   logic                    flush;
   logic [1:0]              deq_valid;
   logic [31:0]             deq_inst0;
   logic [31:0]             deq_pc0;
   logic [31:0]             deq_inst1;
   logic [31:0]             deq_pc1;
   logic [1:0]              deq_cnt;
   logic [$clog2(DEPTH):0]  count;

   int n_assert = 0;
   int n_fail   = 0;

   inst_fetch_queue #(
      .DEPTH        (DEPTH),
      .MAX_INFLIGHT (MAXI)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_fire   (req_fire),
      .req_allow  (req_allow),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_pc    (resp_pc),
      .resp_mask  (resp_mask),
      .flush      (flush),
      .deq_valid  (deq_valid),
      .deq_inst0  (deq_inst0),
      .deq_pc0    (deq_pc0),
      .deq_inst1  (deq_inst1),
      .deq_pc1    (deq_pc1),
      .deq_cnt    (deq_cnt),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge with idle pulses.
   task automatic step();
      @(posedge clk);
      #1;
      req_fire   = 1'b0;
      resp_valid = 1'b0;
      resp_mask  = 2'b00;
      flush      = 1'b0;
      deq_cnt    = 2'd0;
   endtask

   task automatic fire();
      req_fire = 1'b1;
      step();
   endtask

   task automatic resp(input logic [31:0] pc, input logic [1:0] mask, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [1:0] dq);
      resp_valid = 1'b1;
      resp_pc    = pc;
      resp_mask  = mask;
      resp_data  = {i1, i0};
      deq_cnt    = dq;
      step();
   endtask

   initial begin
      reset      = 1'b1;
      req_fire   = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_pc    = '0;
      resp_mask  = 2'b00;
      flush      = 1'b0;
      deq_cnt    = 2'd0;

      // Reset state
      step();
      step();
      chk("rst_allow", req_allow, 0);
      chk("rst_valid", deq_valid, 2'b00);
      chk("rst_count", count, 0);
      reset = 1'b0;
      step();
      chk("post_rst_allow", req_allow, 1);

      // 1: basic dual enqueue
      fire();
      chk("t1_allow_inflight1", req_allow, 1);
      resp(32'hBFC0_0000, 2'b11, 32'h1, 32'h2, 2'd0);
      chk("t1_count", count, 2);
      chk("t1_valid", deq_valid, 2'b11);
      chk("t1_pc0", deq_pc0, 32'hBFC0_0000);
      chk("t1_pc1", deq_pc1, 32'hBFC0_0004);
      chk("t1_inst0", deq_inst0, 32'h1);
      chk("t1_inst1", deq_inst1, 32'h2);

      // 2: throttle on free space
      fire();
      resp(32'hBFC0_0008, 2'b11, 32'h3, 32'h4, 2'd0);
      fire();
      resp(32'hBFC0_0010, 2'b11, 32'h5, 32'h6, 2'd0);
      chk("t2_count6", count, 6);
      chk("t2_allow_c6", req_allow, 1);
      fire();
      chk("t2_allow_blocked", req_allow, 0);
      deq_cnt = 2'd2;
      step();
      chk("t2_count4", count, 4);
      chk("t2_allow_after_deq", req_allow, 1);
      chk("t2_pc0", deq_pc0, 32'hBFC0_0008);
      resp(32'hBFC0_0018, 2'b11, 32'h7, 32'h8, 2'd0);
      chk("t2_count6b", count, 6);

      // 3: simultaneous enqueue and dequeue
      deq_cnt = 2'd2;
      step();
      deq_cnt = 2'd2;
      step();
      deq_cnt = 2'd1;
      step();
      chk("t3_count1", count, 1);
      chk("t3_valid01", deq_valid, 2'b01);
      chk("t3_pc0_old", deq_pc0, 32'hBFC0_001C);
      fire();
      resp(32'h0000_1000, 2'b11, 32'h11, 32'h22, 2'd1);
      chk("t3_count2", count, 2);
      chk("t3_inst0_new", deq_inst0, 32'h11);
      chk("t3_pc0_new", deq_pc0, 32'h0000_1000);
      chk("t3_pc1_new", deq_pc1, 32'h0000_1004);

      // 4: flush with two requests outstanding
      fire();
      resp(32'h0000_2000, 2'b11, 32'h21, 32'h23, 2'd0);
      chk("t4_count4", count, 4);
      fire();
      chk("t4_allow_if1", req_allow, 1);
      fire();
      chk("t4_allow_if2", req_allow, 0);
      flush = 1'b1;
      step();
      chk("t4_flush_count", count, 0);
      chk("t4_flush_valid", deq_valid, 2'b00);
      chk("t4_allow_drop2", req_allow, 0);
      resp(32'h0000_2008, 2'b11, 32'hDEAD, 32'hBEEF, 2'd0);
      chk("t4_drop1_count", count, 0);
      chk("t4_allow_drop1", req_allow, 1);
      resp(32'h0000_2010, 2'b11, 32'hDEAD, 32'hBEEF, 2'd0);
      chk("t4_drop2_count", count, 0);
      fire();
      resp(32'h0000_3000, 2'b11, 32'h33, 32'h34, 2'd0);
      chk("t4_new_count", count, 2);
      chk("t4_new_pc0", deq_pc0, 32'h0000_3000);
      chk("t4_new_inst0", deq_inst0, 32'h33);

      // 5: steady push/pop two per cycle across pointer wrap
      fire();
      for (int k = 0; k < 10; k++) begin
         req_fire = 1'b1;
         resp(32'h0000_3008 + 32'(8 * k), 2'b11, 32'(100 + 2 * k), 32'(101 + 2 * k), 2'd2);
         chk($sformatf("t5_count_%0d", k), count, 2);
         chk($sformatf("t5_pc0_%0d", k), deq_pc0, 32'h0000_3008 + 32'(8 * k));
         chk($sformatf("t5_pc1_%0d", k), deq_pc1, 32'h0000_300C + 32'(8 * k));
         chk($sformatf("t5_inst0_%0d", k), deq_inst0, 32'(100 + 2 * k));
      end

      // 6: single-slot response, then reset mid-request
      deq_cnt = 2'd2;
      step();
      chk("t6_drained", count, 0);
      resp(32'h8000_0010, 2'b01, 32'hAA, 32'h0, 2'd0);
      chk("t6_count1", count, 1);
      chk("t6_valid01", deq_valid, 2'b01);
      chk("t6_pc0", deq_pc0, 32'h8000_0010);
      chk("t6_inst0", deq_inst0, 32'hAA);
      fire();
      chk("t6_allow_if1", req_allow, 1);
      reset = 1'b1;
      step();
      chk("t6_rst_count", count, 0);
      chk("t6_rst_allow", req_allow, 0);
      chk("t6_rst_valid", deq_valid, 2'b00);
      reset = 1'b0;
      step();
      chk("t6_rel_allow", req_allow, 1);
      chk("t6_rel_count", count, 0);
      fire();
      chk("t6_inflight_cleared", req_allow, 1);
      resp(32'h8000_0020, 2'b00, 32'h0, 32'h0, 2'd0);
      chk("t6_mask00_count", count, 0);
      chk("t6_mask00_allow", req_allow, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
